// File: rtl/traffic_light_sequencer_if.sv
// Control/status bundle between the menu controller (master) and the
// light sequencer (slave); the sequencer's status also feeds the lamp renderer.
interface traffic_light_sequencer_if;
  logic [1:0] sim_state;
  logic [7:0] green_duration;
  logic [7:0] yellow_duration;
  logic [7:0] red_holding;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [7:0] seconds_left;
  logic       sec_tick;

  modport master (
    output sim_state, green_duration, yellow_duration, red_holding,
    input  ns_light, ew_light, phase, seconds_left, sec_tick
  );

  modport slave (
    input  sim_state, green_duration, yellow_duration, red_holding,
    output ns_light, ew_light, phase, seconds_left, sec_tick
  );
endinterface

// File: rtl/traffic_light_sequencer.sv
// Two-road intersection sequencer: green/yellow/all-red phases timed in
// seconds by a CLK_HZ prescaler, with run/pause/stop control.
module traffic_light_sequencer #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  traffic_light_sequencer_if.slave   bus
);
  localparam int              PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [1:0]      ST_STOP = 2'b00;
  localparam logic [1:0]      ST_RUN  = 2'b01;
  localparam logic [2:0]      RED     = 3'b100;
  localparam logic [2:0]      YEL     = 3'b010;
  localparam logic [2:0]      GRN     = 3'b001;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_A = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALL_RED_B = 3'd6
  } phase_t;

  phase_t          state;
  logic [PW-1:0]   pres;
  logic [7:0]      secs;
  logic [2:0]      ns, ew;
  logic            tick;

  function automatic logic [7:0] clamp1(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  // A zero all-red hold routes yellow straight to the other road's green.
  function automatic phase_t next_phase(input phase_t p, input logic skip_red);
    case (p)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return skip_red ? EW_GREEN : ALL_RED_A;
      ALL_RED_A: return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return skip_red ? NS_GREEN : ALL_RED_B;
      ALL_RED_B: return NS_GREEN;
      default:   return IDLE;
    endcase
  endfunction

  function automatic logic [7:0] dur_of(input phase_t p, input logic [7:0] g,
                                        input logic [7:0] y, input logic [7:0] r);
    case (p)
      NS_GREEN, EW_GREEN:   return clamp1(g);
      NS_YELLOW, EW_YELLOW: return clamp1(y);
      ALL_RED_A, ALL_RED_B: return r;
      default:              return 8'd0;
    endcase
  endfunction

  // Returns {ns, ew}; only one road is ever non-red.
  function automatic logic [5:0] lamps_of(input phase_t p);
    case (p)
      NS_GREEN:  return {GRN, RED};
      NS_YELLOW: return {YEL, RED};
      EW_GREEN:  return {RED, GRN};
      EW_YELLOW: return {RED, YEL};
      default:   return {RED, RED};
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pres  <= '0;
      secs  <= 8'd0;
      ns    <= RED;
      ew    <= RED;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (bus.sim_state == ST_STOP) begin
        state <= IDLE;
        pres  <= '0;
        secs  <= 8'd0;
        ns    <= RED;
        ew    <= RED;
      end else if (bus.sim_state == ST_RUN) begin
        if (state == IDLE) begin
          state    <= NS_GREEN;
          pres     <= '0;
          secs     <= clamp1(bus.green_duration);
          {ns, ew} <= lamps_of(NS_GREEN);
          tick     <= (PRE_MAX == '0);
        end else if (pres == PRE_MAX) begin
          pres <= '0;
          tick <= (PRE_MAX == '0);
          if (secs <= 8'd1) begin
            state    <= next_phase(state, bus.red_holding == 8'd0);
            secs     <= dur_of(next_phase(state, bus.red_holding == 8'd0),
                               bus.green_duration, bus.yellow_duration, bus.red_holding);
            {ns, ew} <= lamps_of(next_phase(state, bus.red_holding == 8'd0));
          end else begin
            secs <= secs - 8'd1;
          end
        end else begin
          pres <= pres + PW'(1);
          tick <= ((pres + PW'(1)) == PRE_MAX);
        end
      end
      // PAUSE (10/11): everything holds, tick already forced low
    end
  end

  assign bus.phase        = state;
  assign bus.seconds_left = secs;
  assign bus.ns_light     = ns;
  assign bus.ew_light     = ew;
  assign bus.sec_tick     = tick;
endmodule
